// File: rtl/trivium_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trivium_pkg
// Description : Shared constants, tap masks and FSM state type for the
//               Trivium-style stream engine.
// Revision    : 1.0 - initial release
// ============================================================================
package trivium_pkg;

  // Power-on contents of the three shift registers (zero-extended to REG_W)
  localparam logic [19:0] INIT_S1 = 20'h23A2B;
  localparam logic [19:0] INIT_S2 = 20'h2A892;
  localparam logic [19:0] INIT_S3 = 20'hF4511;

  // Byte replicated across the key to derive the s3 load value
  localparam logic [7:0] KEY_MIX_BYTE = 8'hA5;

  // Feedback tap masks: Fn_Sm selects the bits of register m that feed the
  // new LSB of register n. All taps live in the low 64 bits.
  localparam logic [63:0] F1_S1 = (64'd1 << 5) | (64'd1 << 31);
  localparam logic [63:0] F1_S2 = (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 47);
  localparam logic [63:0] F1_S3 = (64'd1 << 1) | (64'd1 << 13) | (64'd1 << 60);

  localparam logic [63:0] F2_S1 = (64'd1 << 1) | (64'd1 << 23);
  localparam logic [63:0] F2_S2 = (64'd1 << 2);
  localparam logic [63:0] F2_S3 = (64'd1 << 3) | (64'd1 << 19);

  localparam logic [63:0] F3_S1 = (64'd1 << 5) | (64'd1 << 10) | (64'd1 << 17);
  localparam logic [63:0] F3_S2 = (64'd1 << 2) | (64'd1 << 29) | (64'd1 << 40);
  localparam logic [63:0] F3_S3 = (64'd1 << 4) | (64'd1 << 63);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WARM = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  // XOR of the register bits selected by a tap mask
  function automatic logic tap_parity(input logic [63:0] s, input logic [63:0] mask);
    return ^(s & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trivium_stream_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : trivium_stream_engine_if
// Description : Key handshake plus input/output valid-ready streams of the
//               stream engine. The engine takes the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface trivium_stream_engine_if #(
  parameter int DATA_W = 8,
  parameter int KEY_W  = 16
);
  logic              key_valid;
  logic              key_ready;
  logic [KEY_W-1:0]  key_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  modport slave (
    input  key_valid, key_in, in_valid, in_data, out_ready,
    output key_ready, in_ready, out_valid, out_data, busy
  );

  modport master (
    output key_valid, key_in, in_valid, in_data, out_ready,
    input  key_ready, in_ready, out_valid, out_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/trivium_core.sv
`default_nettype none
// ============================================================================
// Module      : trivium_core
// Description : Three REG_W-bit feedback shift registers producing one
//               keystream bit per enabled step; parallel load has priority.
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_core
  import trivium_pkg::*;
#(
  parameter int REG_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [REG_W-1:0] load_s1,
  input  logic [REG_W-1:0] load_s2,
  input  logic [REG_W-1:0] load_s3,
  input  logic             step_en,
  output logic             k
);

  logic [REG_W-1:0] s1_q, s1_d;
  logic [REG_W-1:0] s2_q, s2_d;
  logic [REG_W-1:0] s3_q, s3_d;
  logic             fb1, fb2, fb3;

  assign k = s1_q[0] ^ s2_q[0] ^ s3_q[0];

  // Feedback bits from the current state, then load / step / hold selection
  always_comb begin
    fb1 = tap_parity(s1_q[63:0], F1_S1) ^ tap_parity(s2_q[63:0], F1_S2)
        ^ tap_parity(s3_q[63:0], F1_S3);
    fb2 = tap_parity(s1_q[63:0], F2_S1) ^ tap_parity(s2_q[63:0], F2_S2)
        ^ tap_parity(s3_q[63:0], F2_S3);
    fb3 = tap_parity(s1_q[63:0], F3_S1) ^ tap_parity(s2_q[63:0], F3_S2)
        ^ tap_parity(s3_q[63:0], F3_S3);
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    if (load_en) begin
      s1_d = load_s1;
      s2_d = load_s2;
      s3_d = load_s3;
    end else if (step_en) begin
      s1_d = {s1_q[REG_W-2:0], fb1};
      s2_d = {s2_q[REG_W-2:0], fb2};
      s3_d = {s3_q[REG_W-2:0], fb3};
    end
  end

  // Register update with reset to the fixed initial contents
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= REG_W'(INIT_S1);
      s2_q <= REG_W'(INIT_S2);
      s3_q <= REG_W'(INIT_S3);
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/trivium_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : trivium_stream_engine
// Description : Keyed stream cipher engine: key load, warm-up discard, then
//               DATA_W keystream bits XORed onto each accepted input word.
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_stream_engine
  import trivium_pkg::*;
#(
  parameter int REG_W  = 64,
  parameter int DATA_W = 8,
  parameter int KEY_W  = 16,
  parameter int WARMUP = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  trivium_stream_engine_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int WC_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CNT_W-1:0] C_CNT_FULL  = CNT_W'(DATA_W);
  localparam logic [WC_W-1:0]  C_WARM_LAST = WC_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0] ks_word_q, ks_word_d;
  logic [CNT_W-1:0]  ks_cnt_q, ks_cnt_d;
  logic [WC_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              key_ready, key_hs, in_ready, accept;
  logic              gen_en, step_en, load_en, busy, ks_bit;
  logic [KEY_W-1:0]  key_inv, key_mix;

  // Key-derived load values; inverted and mixed keys are kept at KEY_W bits
  // so the zero-extension happens after the bitwise operation.
  assign key_inv = ~key_q;
  assign key_mix = key_q ^ {(KEY_W / 8){KEY_MIX_BYTE}};

  trivium_core #(.REG_W(REG_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_en (load_en),
    .load_s1 (REG_W'(INIT_S1) ^ REG_W'(key_q)),
    .load_s2 (REG_W'(INIT_S2) ^ REG_W'(key_inv)),
    .load_s3 (REG_W'(INIT_S3) ^ REG_W'(key_mix)),
    .step_en (step_en),
    .k       (ks_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a key handshake from RUN restarts the load sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (key_hs) state_d = ST_LOAD;
      ST_LOAD: state_d = (WARMUP == 0) ? ST_RUN : ST_WARM;
      ST_WARM: if (warm_cnt_q == C_WARM_LAST) state_d = ST_RUN;
      ST_RUN:  if (key_hs) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded controls; a key handshake blocks a data accept that cycle
  always_comb begin
    key_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    key_hs    = bus.key_valid && key_ready;
    busy      = (state_q == ST_LOAD) || (state_q == ST_WARM);
    load_en   = (state_q == ST_LOAD);
    gen_en    = (state_q == ST_RUN) && (ks_cnt_q != C_CNT_FULL);
    step_en   = (state_q == ST_WARM) || gen_en;
    in_ready  = (state_q == ST_RUN) && (ks_cnt_q == C_CNT_FULL)
              && (!out_valid_q || bus.out_ready) && !key_hs;
    accept    = bus.in_valid && in_ready;
  end

  // Counters, keystream word gathering (first bit ends in MSB) and output reg
  always_comb begin
    key_d       = key_q;
    ks_word_d   = ks_word_q;
    ks_cnt_d    = ks_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (key_hs) key_d = bus.key_in;
    if (state_q == ST_LOAD) begin
      ks_word_d  = '0;
      ks_cnt_d   = '0;
      warm_cnt_d = '0;
    end
    if (state_q == ST_WARM) warm_cnt_d = warm_cnt_q + WC_W'(1);
    if (gen_en) begin
      ks_word_d = (ks_word_q << 1) | DATA_W'(ks_bit);
      ks_cnt_d  = ks_cnt_q + CNT_W'(1);
    end
    if (accept) begin
      ks_cnt_d    = '0;
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data ^ ks_word_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      ks_word_q   <= '0;
      ks_cnt_q    <= '0;
      warm_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      key_q       <= key_d;
      ks_word_q   <= ks_word_d;
      ks_cnt_q    <= ks_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.key_ready = key_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy;

endmodule
`default_nettype wire
